// File: rtl/pwm_spi_pkg.sv
// pwm_spi_pkg: shared state encodings, command layout and defaults for the SPI register controller
package pwm_spi_pkg;
  localparam int NUM_REGS_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int RW_BIT = 7;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    ERROR = 3'd4
  } state_t;
endpackage

// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: byte stream from the SPI shifter plus register-file write/read port
interface spi_reg_ctrl_if #(parameter int ADDR_W = 4);
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [7:0]        rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        tx_byte;
  logic              tx_load;
  modport master (
    input  rx_valid, rx_byte, rd_data,
    output wr_en, wr_addr, wr_data, rd_addr, tx_byte, tx_load
  );
  modport slave (
    output rx_valid, rx_byte, rd_data,
    input  wr_en, wr_addr, wr_data, rd_addr, tx_byte, tx_load
  );
endinterface

// File: rtl/cs_sync_edge.sv
// cs_sync_edge: two-flop synchronizer for the async chip select plus one-cycle edge pulses
module cs_sync_edge (
  input  logic CLK,
  input  logic _RST,
  input  logic _CS,
  output logic cs_fall,
  output logic cs_rise
);
  logic [2:0] sync;
  always_ff @(posedge CLK or negedge _RST)
    if (!_RST) sync <= '1;
    else sync <= {sync[1:0], _CS};
  // sync[1] is the synchronized level, sync[2] its previous value
  assign cs_fall = sync[2] & ~sync[1];
  assign cs_rise = ~sync[2] & sync[1];
endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns SPI command/data bytes into auto-incrementing register writes and read-backs
module spi_reg_ctrl
  import pwm_spi_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic           CLK,
  input  logic           _RST,
  input  logic           _CS,
  spi_reg_ctrl_if.master bus,
  output logic           busy,
  output logic           err
);
  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d, cmd_addr, wr_addr_d;
  logic [7:0]        wr_data_d, tx_byte_d;
  logic              cs_fall, cs_rise, err_d, wr_en_d, tx_load_d;

  cs_sync_edge u_cs (
    .CLK     (CLK),
    ._RST    (_RST),
    ._CS     (_CS),
    .cs_fall (cs_fall),
    .cs_rise (cs_rise)
  );

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (int'(a) == NUM_REGS - 1) ? '0 : a + 1'b1;
  endfunction

  assign cmd_addr = bus.rx_byte[ADDR_W-1:0];
  // a read command looks up its start register in the same cycle so the first byte is ready next cycle
  assign bus.rd_addr = (state == CMD && bus.rx_valid) ? cmd_addr : addr;
  assign busy = state != IDLE;

  always_comb begin
    state_d   = state;
    addr_d    = addr;
    err_d     = err;
    wr_en_d   = 1'b0;
    tx_load_d = 1'b0;
    wr_addr_d = bus.wr_addr;
    wr_data_d = bus.wr_data;
    tx_byte_d = bus.tx_byte;
    if (cs_fall) begin
      state_d = CMD;
      addr_d  = '0;
      err_d   = 1'b0;
    end else if (cs_rise) begin
      state_d = IDLE;
    end else if (bus.rx_valid) begin
      case (state)
        CMD:
          if (int'(cmd_addr) >= NUM_REGS) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (bus.rx_byte[RW_BIT]) begin
            state_d   = READ;
            tx_load_d = 1'b1;
            tx_byte_d = bus.rd_data;
            addr_d    = next_addr(cmd_addr);
          end else begin
            state_d = WRITE;
            addr_d  = cmd_addr;
          end
        WRITE: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr;
          wr_data_d = bus.rx_byte;
          addr_d    = next_addr(addr);
        end
        READ: begin
          tx_load_d = 1'b1;
          tx_byte_d = bus.rd_data;
          addr_d    = next_addr(addr);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge _RST)
    if (!_RST) begin
      state       <= IDLE;
      addr        <= '0;
      err         <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.tx_byte <= '0;
      bus.tx_load <= 1'b0;
    end else begin
      state       <= state_d;
      addr        <= addr_d;
      err         <= err_d;
      bus.wr_en   <= wr_en_d;
      bus.wr_addr <= wr_addr_d;
      bus.wr_data <= wr_data_d;
      bus.tx_byte <= tx_byte_d;
      bus.tx_load <= tx_load_d;
    end
endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter: NUM_REGS, 16, number of PWM channel registers addressed (2..16).
REQ-002 Parameter: ADDR_W, 4, register address width.
REQ-003 CLK  input  1  system clock; all state on rising edge.
REQ-004 _RST  input  1  reset, asynchronous, active-low.
REQ-005 _CS  input  1  SPI chip select, active-low, asynchronous to CLK.
REQ-006 rx_valid  input  1  one-CLK pulse: rx_byte holds a complete received SPI byte.
REQ-007 rx_byte  input  8  received byte, valid only with rx_valid.
REQ-008 rd_data  input  8  register-file read data, combinational from rd_addr.
REQ-009 wr_en  output  1  one-cycle register write strobe.
REQ-010 wr_addr  output  ADDR_W  write address, valid with wr_en.
REQ-011 wr_data  output  8  write data, valid with wr_en.
REQ-012 rd_addr  output  ADDR_W  current transaction address.
REQ-013 tx_byte  output  8  byte for the SPI shifter's next transmit.
REQ-014 tx_load  output  1  one-cycle pulse: shifter loads tx_byte.
REQ-015 busy  output  1  high while a transaction is active (states other than IDLE).
REQ-016 err  output  1  sticky: last transaction had an out-of-range address.

Function
REQ-017 _CS SHALL pass a 2-flop synchronizer; cs_fall/cs_rise are one-cycle pulses from synchronized edges.
REQ-018 States: IDLE, CMD, WRITE, READ, ERROR; encoding SHALL be 3 bits.
REQ-019 IDLE -> CMD on cs_fall; err cleared, addr register cleared same cycle.
REQ-020 In CMD, first rx_valid is the command: bit7 = 1 read / 0 write, bits[ADDR_W-1:0] = start address, bits[6:ADDR_W] ignored.
REQ-021 Command address >= NUM_REGS -> ERROR, err=1; all further bytes ignored, no wr_en/tx_load.
REQ-022 Valid write command -> WRITE; each later rx_valid SHALL give wr_en=1 the next cycle with wr_addr=addr, wr_data=rx_byte, then addr increments.
REQ-023 Valid read command -> READ; the next cycle tx_load=1, tx_byte=rd_data at rd_addr=start address, then addr increments.
REQ-024 In READ each later rx_valid (dummy byte) SHALL produce tx_load one cycle later with the next register; rx_byte value ignored.
REQ-025 Address increment SHALL wrap NUM_REGS-1 -> 0, in both WRITE and READ.
REQ-026 cs_rise in any state SHALL return to IDLE next cycle; no wr_en/tx_load issued from that edge onward.
REQ-027 rx_valid in the same cycle as cs_rise, or while in IDLE, SHALL be discarded.
REQ-028 cs_fall seen while not IDLE (missed rise) SHALL restart at CMD.
REQ-029 wr_en and tx_load SHALL never be high in the same cycle; each is high at most one cycle per received byte.

Reset
REQ-030 On _RST low: state=IDLE, addr=0, wr_en=0, wr_addr=0, wr_data=0, tx_byte=0, tx_load=0, busy=0, err=0, synchronizer flops=1 (deasserted CS).
REQ-031 Reset mid-transaction SHALL abort with no further write; the bus resumes only on a new cs_fall after release.

Structure
REQ-032 State encodings, command-bit positions (RW_BIT=7) and NUM_REGS default SHALL live in the shared package pwm_spi_pkg.
REQ-033 CS synchronizer plus edge detect SHALL be one sub-module, cs_sync_edge; the rest is a single FSM + datapath.

Verification
REQ-034 Write burst: cs_fall, bytes 0x02,0xAA,0xBB, cs_rise -> wr_en at (2,0xAA),(3,0xBB), err=0, busy low after rise.
REQ-035 Wrap: NUM_REGS=16, command 0x0F, data 0x11,0x22 -> writes (15,0x11),(0,0x22).
REQ-036 Read: regs[5]=0x5A, regs[6]=0xC3; command 0x85, one dummy -> tx_load with 0x5A then 0xC3.
REQ-037 Out of range: NUM_REGS=8, command 0x0A, data 0x77 -> err=1, no wr_en; next transaction clears err.
REQ-038 Abort: cs_rise same cycle as data rx_valid -> no wr_en; _RST pulse mid-burst -> all outputs at REQ-030 values.
